// File: rtl/data_change_queue.sv
// data_change_queue
//   Watches CHANNELS independent WIDTH-bit words and turns every value change
//   into a (channel, value) event. Each channel has a one-deep pending stage; a
//   round-robin arbiter moves at most one pending event per cycle into a
//   first-word-fall-through FIFO that drives a valid/ready output. Changes that
//   hit a channel whose previous change is still pending are either merged
//   (COALESCE=1, latest value wins) or dropped and counted (COALESCE=0).
//
// Ports
//   clk            single clock
//   reset          synchronous, active-high; shadows keep loading dataIn
//   dataIn         channel c at bits [c*WIDTH +: WIDTH]
//   dataOut        value of head event (0 when empty)
//   chanOut        channel index of head event (0 when empty)
//   validOut       head event available
//   readyIn        consumer takes the head event (ignored when validOut=0)
//   level          FIFO occupancy, 0..DEPTH
//   overflow       sticky drop flag
//   dropCount      saturating count of dropped changes
//   clearOverflow  zeroes overflow/dropCount; same-cycle drops still land
module data_change_queue #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned COALESCE = 0,
  localparam int unsigned ChanW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned LevelW  = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0]          dataOut,
  output logic [ChanW-1:0]          chanOut,
  output logic                      validOut,
  input  logic                      readyIn,
  output logic [LevelW-1:0]         level,
  output logic                      overflow,
  output logic [15:0]               dropCount,
  input  logic                      clearOverflow
);

  localparam int unsigned        AddrW    = LevelW - 1;
  localparam logic [LevelW-1:0]  Full     = LevelW'(DEPTH);
  localparam logic [ChanW-1:0]   LastChan = ChanW'(CHANNELS - 1);

  typedef logic [WIDTH-1:0] word_t;

  word_t               din      [CHANNELS];
  word_t               shadow_q [CHANNELS];
  word_t               snap_q   [CHANNELS];
  word_t               snap_d   [CHANNELS];
  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] gnt;

  logic [ChanW-1:0]    rr_q, rr_d;
  logic [ChanW-1:0]    gnt_idx;
  logic                gnt_any;
  logic                grant;
  word_t               push_data;

  logic [ChanW+WIDTH-1:0] mem_q [DEPTH];
  logic [ChanW+WIDTH-1:0] head;
  logic [AddrW-1:0]       wr_q, rd_q;
  logic [LevelW-1:0]      level_q, level_d;
  logic                   not_empty, push, pop, push_ok;

  logic [4:0]  n_drop;
  logic [16:0] drop_sum;
  logic [15:0] drop_q, drop_d;
  logic        overflow_q, overflow_d;

  // Change detect against last cycle's sample.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      din[c] = dataIn[c*WIDTH +: WIDTH];
      chg[c] = (din[c] != shadow_q[c]);
    end
  end

  // FIFO handshake. A push is allowed into a full FIFO only when the head
  // leaves in the same cycle.
  always_comb begin
    not_empty = (level_q != '0);
    pop       = not_empty && readyIn;
    push_ok   = (level_q != Full) || pop;
  end

  // Round-robin search: first pass covers channels at or above the pointer,
  // second pass wraps to the channels below it.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    push_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (!gnt_any && pend_q[c] && (ChanW'(c) >= rr_q)) begin
        gnt_any   = 1'b1;
        gnt_idx   = ChanW'(c);
        push_data = snap_q[c];
      end
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (!gnt_any && pend_q[c]) begin
        gnt_any   = 1'b1;
        gnt_idx   = ChanW'(c);
        push_data = snap_q[c];
      end
    end
    grant = gnt_any && push_ok;
    push  = grant;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      gnt[c] = grant && (gnt_idx == ChanW'(c));
    end
    rr_d = rr_q;
    if (grant) begin
      rr_d = (gnt_idx == LastChan) ? '0 : gnt_idx + ChanW'(1);
    end
  end

  // Pending stage and drop accounting.
  always_comb begin
    n_drop = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pend_d[c] = pend_q[c];
      snap_d[c] = snap_q[c];
      if (gnt[c]) begin
        // A change landing on the granted channel refills the slot it vacates.
        pend_d[c] = chg[c];
        if (chg[c]) snap_d[c] = din[c];
      end else if (chg[c]) begin
        if (!pend_q[c]) begin
          pend_d[c] = 1'b1;
          snap_d[c] = din[c];
        end else if (COALESCE != 0) begin
          snap_d[c] = din[c];
        end else begin
          n_drop = n_drop + 5'd1;
        end
      end
    end
    // Clear first, then add this cycle's drops.
    drop_sum   = {1'b0, (clearOverflow ? 16'h0 : drop_q)} + 17'(n_drop);
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = (clearOverflow ? 1'b0 : overflow_q) | (n_drop != '0);
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      if (push) wr_q <= wr_q + AddrW'(1);
      if (pop)  rd_q <= rd_q + AddrW'(1);
    end
  end

  // Shadows load even during reset so release does not produce an event.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      shadow_q[c] <= din[c];
      if (reset) snap_q[c] <= '0;
      else       snap_q[c] <= snap_d[c];
    end
  end

  // At full with push+pop, wr_q equals rd_q; the old head is read before the edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {gnt_idx, push_data};
  end

  always_comb begin
    head      = mem_q[rd_q];
    validOut  = not_empty;
    dataOut   = not_empty ? head[WIDTH-1:0] : '0;
    chanOut   = not_empty ? head[ChanW+WIDTH-1:WIDTH] : '0;
    level     = level_q;
    overflow  = overflow_q;
    dropCount = drop_q;
  end

endmodule

// File: tb/tb_data_change_queue.sv
// Bench for data_change_queue: two instances (COALESCE=0 and 1) share the
// same stimulus; directed scenarios plus a randomized run against a queue-based
// reference model.
module tb_data_change_queue;

  localparam int W   = 24;
  localparam int NCH = 6;
  localparam int D   = 4;
  localparam int CW  = 3;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           readyIn = 1'b0;
  logic           clearOverflow = 1'b0;
  logic [W-1:0]   chv [NCH];
  logic [NCH*W-1:0] dataIn;

  logic [W-1:0]   o_data  [2];
  logic [CW-1:0]  o_chan  [2];
  logic           o_valid [2];
  logic [LW-1:0]  o_level [2];
  logic           o_ovf   [2];
  logic [15:0]    o_drop  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    dataIn = '0;
    for (int c = 0; c < NCH; c++) dataIn[c*W +: W] = chv[c];
  end

  data_change_queue #(.WIDTH(W), .CHANNELS(NCH), .DEPTH(D), .COALESCE(0)) dut0 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataOut(o_data[0]), .chanOut(o_chan[0]),
    .validOut(o_valid[0]), .readyIn(readyIn), .level(o_level[0]), .overflow(o_ovf[0]),
    .dropCount(o_drop[0]), .clearOverflow(clearOverflow)
  );

  data_change_queue #(.WIDTH(W), .CHANNELS(NCH), .DEPTH(D), .COALESCE(1)) dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataOut(o_data[1]), .chanOut(o_chan[1]),
    .validOut(o_valid[1]), .readyIn(readyIn), .level(o_level[1]), .overflow(o_ovf[1]),
    .dropCount(o_drop[1]), .clearOverflow(clearOverflow)
  );

  // ---------------- reference model (index m = COALESCE value) ----------------
  logic [W-1:0] m_shadow [2][NCH];
  logic [W-1:0] m_snap   [2][NCH];
  bit           m_pend   [2][NCH];
  int           m_rr     [2];
  int           m_drop   [2];
  bit           m_ovf    [2];
  logic [31:0]  mq0 [$];
  logic [31:0]  mq1 [$];

  function automatic int qsize(int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [31:0] qhead(int m);
    if (m == 0) return mq0[0];
    return mq1[0];
  endfunction

  function automatic void qpush(int m, logic [31:0] e);
    if (m == 0) mq0.push_back(e);
    else        mq1.push_back(e);
  endfunction

  function automatic void qpop(int m);
    if (m == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endfunction

  function automatic void qclear(int m);
    if (m == 0) mq0.delete();
    else        mq1.delete();
  endfunction

  function automatic void model_step(int m);
    int n, g, nd;
    bit pop, room, chg;
    if (reset) begin
      qclear(m);
      for (int c = 0; c < NCH; c++) begin
        m_pend[m][c]   = 1'b0;
        m_snap[m][c]   = '0;
        m_shadow[m][c] = chv[c];
      end
      m_rr[m]   = 0;
      m_drop[m] = 0;
      m_ovf[m]  = 1'b0;
      return;
    end
    n    = qsize(m);
    pop  = (n > 0) && readyIn;
    room = (n < D) || pop;
    g    = -1;
    if (room) begin
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && m_pend[m][(m_rr[m] + k) % NCH]) g = (m_rr[m] + k) % NCH;
      end
    end
    if (pop) qpop(m);
    if (g >= 0) begin
      qpush(m, {8'(g), m_snap[m][g]});
      m_rr[m] = (g + 1) % NCH;
    end
    nd = 0;
    for (int c = 0; c < NCH; c++) begin
      chg = (chv[c] != m_shadow[m][c]);
      if (c == g) begin
        m_pend[m][c] = chg;
        if (chg) m_snap[m][c] = chv[c];
      end else if (chg) begin
        if (!m_pend[m][c]) begin
          m_pend[m][c] = 1'b1;
          m_snap[m][c] = chv[c];
        end else if (m == 1) begin
          m_snap[m][c] = chv[c];
        end else begin
          nd++;
        end
      end
      m_shadow[m][c] = chv[c];
    end
    if (clearOverflow) begin
      m_drop[m] = 0;
      m_ovf[m]  = 1'b0;
    end
    if (nd > 0) begin
      m_ovf[m]  = 1'b1;
      m_drop[m] = (m_drop[m] + nd > 65535) ? 65535 : m_drop[m] + nd;
    end
  endfunction

  // One clock: model advances with the DUT edge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    readyIn = 1'b0;
    clearOverflow = 1'b0;
    for (int c = 0; c < NCH; c++) chv[c] = 24'h111111;
    tick();
    for (int c = 0; c < NCH; c++) chv[c] = 24'h123456;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b0 || o_level[m] !== 3'd0 || o_ovf[m] !== 1'b0 ||
          o_drop[m] !== 16'h0 || o_data[m] !== 24'h0 || o_chan[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: valid=%b level=%0d ovf=%b drop=%0d data=%h chan=%0d, required all 0",
                 m, o_valid[m], o_level[m], o_ovf[m], o_drop[m], o_data[m], o_chan[m]);
      end
    end
    reset = 1'b0;
    readyIn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (o_valid[m] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_release dut%0d cycle %0d: validOut=%b, required 0", m, i, o_valid[m]);
        end
      end
    end
  endtask

  task automatic test_single();
    readyIn = 1'b1;
    chv[2] = 24'hABCDEF;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_latency dut%0d: validOut=%b one edge after change, required 0", m, o_valid[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b1 || o_chan[m] !== 3'd2 || o_data[m] !== 24'hABCDEF || o_level[m] !== 3'd1) begin
        n_fail++;
        $display("FAIL single_event dut%0d: valid=%b chan=%0d data=%h level=%0d, required 1/2/abcdef/1",
                 m, o_valid[m], o_chan[m], o_data[m], o_level[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b0 || o_level[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL single_pop dut%0d: valid=%b level=%0d, required 0/0", m, o_valid[m], o_level[m]);
      end
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    readyIn = 1'b1;
    for (int c = 0; c < 4; c++) chv[c] = 24'h100000 + 24'(c);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (o_valid[m] !== 1'b1 || o_chan[m] !== 3'(i) || o_data[m] !== 24'h100000 + 24'(i)) begin
          n_fail++;
          $display("FAIL rr_order dut%0d slot %0d: valid=%b chan=%0d data=%h, required 1/%0d/%h",
                   m, i, o_valid[m], o_chan[m], o_data[m], i, 24'h100000 + 24'(i));
        end
      end
    end
    tick();
    chv[0] = 24'h200000;
    chv[3] = 24'h200003;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b1 || o_chan[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL rr_pair_first dut%0d: valid=%b chan=%0d, required 1/0", m, o_valid[m], o_chan[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b1 || o_chan[m] !== 3'd3 || o_data[m] !== 24'h200003) begin
        n_fail++;
        $display("FAIL rr_pair_second dut%0d: valid=%b chan=%0d data=%h, required 1/3/200003",
                 m, o_valid[m], o_chan[m], o_data[m]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] got_chan [2][8];
    logic [W-1:0]  got_data [2][8];
    int            cnt [2];
    do_reset();
    readyIn = 1'b0;
    for (int c = 0; c < NCH; c++) chv[c] = 24'h300000 + 24'(c);
    for (int i = 0; i < 7; i++) tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_level[m] !== 3'd4 || o_valid[m] !== 1'b1 || o_chan[m] !== 3'd0 ||
          o_drop[m] !== 16'h0 || o_ovf[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_full dut%0d: level=%0d valid=%b chan=%0d drop=%0d ovf=%b, required 4/1/0/0/0",
                 m, o_level[m], o_valid[m], o_chan[m], o_drop[m], o_ovf[m]);
      end
    end
    // Head must hold steady under backpressure.
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_chan[m] !== 3'd0 || o_data[m] !== 24'h300000) begin
        n_fail++;
        $display("FAIL bp_hold dut%0d: chan=%0d data=%h, required 0/300000", m, o_chan[m], o_data[m]);
      end
    end
    readyIn = 1'b1;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (o_valid[m] === 1'b1 && cnt[m] < 8) begin
          got_chan[m][cnt[m]] = o_chan[m];
          got_data[m][cnt[m]] = o_data[m];
          cnt[m]++;
        end
      end
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt[m] != 6 || o_level[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL bp_drain_count dut%0d: events=%0d level=%0d, required 6/0", m, cnt[m], o_level[m]);
      end
      for (int k = 0; k < 6; k++) begin
        if (k < cnt[m]) begin
          n_tests++;
          if (got_chan[m][k] !== 3'(k) || got_data[m][k] !== 24'h300000 + 24'(k)) begin
            n_fail++;
            $display("FAIL bp_drain_order dut%0d slot %0d: chan=%0d data=%h, required %0d/%h",
                     m, k, got_chan[m][k], got_data[m][k], k, 24'h300000 + 24'(k));
          end
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] ch1_val [2];
    bit           found [2];
    do_reset();
    readyIn = 1'b0;
    chv[0] = 24'h400000;
    chv[2] = 24'h400002;
    chv[3] = 24'h400003;
    chv[4] = 24'h400004;
    for (int i = 0; i < 6; i++) tick();
    chv[1] = 24'd5;
    tick();
    chv[1] = 24'd6;
    tick();
    chv[1] = 24'd7;
    tick();
    n_tests++;
    if (o_drop[0] !== 16'd2 || o_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_count_keepfirst: drop=%0d ovf=%b, required 2/1", o_drop[0], o_ovf[0]);
    end
    n_tests++;
    if (o_drop[1] !== 16'd0 || o_ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_count_coalesce: drop=%0d ovf=%b, required 0/0", o_drop[1], o_ovf[1]);
    end
    readyIn = 1'b1;
    found[0] = 1'b0;
    found[1] = 1'b0;
    ch1_val[0] = '0;
    ch1_val[1] = '0;
    for (int i = 0; i < 12; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (o_valid[m] === 1'b1 && o_chan[m] === 3'd1) begin
          found[m]   = 1'b1;
          ch1_val[m] = o_data[m];
        end
      end
      tick();
    end
    n_tests++;
    if (!found[0] || ch1_val[0] !== 24'd5) begin
      n_fail++;
      $display("FAIL drop_value_keepfirst: found=%b value=%0d, required 1/5", found[0], ch1_val[0]);
    end
    n_tests++;
    if (!found[1] || ch1_val[1] !== 24'd7) begin
      n_fail++;
      $display("FAIL drop_value_coalesce: found=%b value=%0d, required 1/7", found[1], ch1_val[1]);
    end
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    n_tests++;
    if (o_drop[0] !== 16'd0 || o_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_clear: drop=%0d ovf=%b, required 0/0", o_drop[0], o_ovf[0]);
    end
  endtask

  task automatic test_reset_midstream();
    readyIn = 1'b0;
    for (int c = 0; c < 3; c++) chv[c] = 24'h500000 + 24'(c);
    for (int i = 0; i < 4; i++) tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_level[m] !== 3'd3) begin
        n_fail++;
        $display("FAIL mid_fill dut%0d: level=%0d, required 3", m, o_level[m]);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b0 || o_level[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d: valid=%b level=%0d, required 0/0", m, o_valid[m], o_level[m]);
      end
    end
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (o_valid[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after dut%0d: valid=%b, required 0", m, o_valid[m]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    readyIn = 1'b0;
    for (int i = 0; i < 11500; i++) begin
      for (int c = 0; c < NCH; c++) chv[c] = ~chv[c];
      tick();
    end
    tick();
    n_tests++;
    if (o_drop[0] !== 16'hFFFF || o_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_count: drop=%h ovf=%b, required ffff/1", o_drop[0], o_ovf[0]);
    end
    n_tests++;
    if (o_drop[1] !== 16'h0 || o_ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_coalesce: drop=%h ovf=%b, required 0/0", o_drop[1], o_ovf[1]);
    end
    // Clear together with one fresh drop: the drop survives the clear.
    chv[0] = ~chv[0];
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    n_tests++;
    if (o_drop[0] !== 16'd1 || o_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_drop: drop=%0d ovf=%b, required 1/1", o_drop[0], o_ovf[0]);
    end
    n_tests++;
    if (o_level[0] !== 3'd4 || o_level[1] !== 3'd4) begin
      n_fail++;
      $display("FAIL sat_level: level0=%0d level1=%0d, required 4/4", o_level[0], o_level[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] h;
    bit          ev;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) chv[c] = 24'($urandom_range(0, 3));
      end
      if (((cyc / 100) % 2) == 0) readyIn = ($urandom_range(0, 3) != 0);
      else                        readyIn = ($urandom_range(0, 4) == 0);
      clearOverflow = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        ev = (qsize(m) != 0);
        n_tests++;
        if (o_valid[m] !== ev || o_level[m] !== 3'(qsize(m))) begin
          n_fail++;
          $display("FAIL rand_level dut%0d cyc %0d: valid=%b level=%0d, required %b/%0d",
                   m, cyc, o_valid[m], o_level[m], ev, qsize(m));
        end
        n_tests++;
        if (o_drop[m] !== 16'(m_drop[m]) || o_ovf[m] !== m_ovf[m]) begin
          n_fail++;
          $display("FAIL rand_drop dut%0d cyc %0d: drop=%0d ovf=%b, required %0d/%b",
                   m, cyc, o_drop[m], o_ovf[m], m_drop[m], m_ovf[m]);
        end
        if (ev) begin
          h = qhead(m);
          n_tests++;
          if (o_data[m] !== h[W-1:0] || o_chan[m] !== h[CW+W-1:W]) begin
            n_fail++;
            $display("FAIL rand_head dut%0d cyc %0d: chan=%0d data=%h, required %0d/%h",
                     m, cyc, o_chan[m], o_data[m], h[CW+W-1:W], h[W-1:0]);
          end
        end
      end
    end
    reset = 1'b0;
    clearOverflow = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) chv[c] = 24'h123456;
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_drop();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
